// File: rtl/wb_host_master.sv
// Wishbone B4 classic initiator: turns one command into one bus cycle and returns one response.
// A cycle that sees no acknowledge within TIMEOUT cycles is aborted and reported as an error.
module wb_host_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic        io_wbs_clk,
    input  logic        io_wbs_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] io_wbm_adr,
    output logic [31:0] io_wbm_datwr,
    input  logic [31:0] io_wbm_datrd,
    output logic        io_wbm_we,
    output logic [3:0]  io_wbm_sel,
    output logic        io_wbm_stb,
    output logic        io_wbm_cyc,
    input  logic        io_wbm_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          we_q;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic [TW-1:0] cnt;
    logic [31:0]   rsp_dat_q;
    logic          rsp_err_q;
    logic          accept;
    logic          timeout_hit;

    assign accept      = (state == IDLE) && cmd_valid;
    assign timeout_hit = (cnt == CNT_LAST);

    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
        if (!io_wbs_rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
        if (!io_wbs_rst_n) begin
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            cnt       <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else if (accept) begin
            we_q  <= cmd_we;
            adr_q <= cmd_adr;
            dat_q <= cmd_dat;
            sel_q <= cmd_sel;
            cnt   <= '0;
        end else if (state == BUS) begin
            // Saturate rather than wrap so a stuck count can never re-arm the timeout.
            if (cnt != '1) cnt <= cnt + TW'(1);
            if (io_wbm_ack) begin
                rsp_dat_q <= we_q ? dat_q : io_wbm_datrd;
                rsp_err_q <= 1'b0;
            end else if (timeout_hit) begin
                rsp_dat_q <= '0;
                rsp_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_nxt    = state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        io_wbm_cyc   = 1'b0;
        io_wbm_stb   = 1'b0;
        io_wbm_adr   = '0;
        io_wbm_datwr = '0;
        io_wbm_we    = 1'b0;
        io_wbm_sel   = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nxt = BUS;
            end
            BUS: begin
                io_wbm_cyc   = 1'b1;
                io_wbm_stb   = 1'b1;
                io_wbm_adr   = adr_q;
                io_wbm_datwr = dat_q;
                io_wbm_we    = we_q;
                io_wbm_sel   = sel_q;
                // Ack takes priority over a coincident timeout.
                if (io_wbm_ack || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_dat = rsp_dat_q;
    assign rsp_err = rsp_err_q;

endmodule
